// File: rtl/vth_sweep_ctrl_if.sv
// Bundle between the sweep sequencer and its controller/capture side.
// Handshake: sample_req rises once a point has settled and stays high until sample_ack is seen at a clock edge.
`timescale 1ns/1ps
interface vth_sweep_ctrl_if #(
    parameter int WIDTH    = 8,
    parameter int SETTLE_W = 16
);
    logic                start;
    logic                abort;
    logic [WIDTH-1:0]    vih_start;
    logic [WIDTH-1:0]    vih_stop;
    logic [WIDTH-1:0]    step;
    logic [WIDTH-1:0]    gap;
    logic [SETTLE_W-1:0] settle;
    logic                sample_ack;
    logic [WIDTH-1:0]    VIH;
    logic [WIDTH-1:0]    VIL;
    logic                sample_req;
    logic                busy;
    logic                done;

    modport master (
        output start, abort, vih_start, vih_stop, step, gap, settle, sample_ack,
        input  VIH, VIL, sample_req, busy, done
    );

    modport slave (
        input  start, abort, vih_start, vih_stop, step, gap, settle, sample_ack,
        output VIH, VIL, sample_req, busy, done
    );
endinterface

// File: rtl/vth_sweep_ctrl.sv
// VIH/VIL threshold sweep sequencer: steps VIH, tracks VIL a fixed gap below,
// settles each point and handshakes with capture before stepping on.
`timescale 1ns/1ps
module vth_sweep_ctrl #(
    parameter int WIDTH    = 8,
    parameter int SETTLE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    vth_sweep_ctrl_if.slave  bus,
    output logic [1:0]       state_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        STEP   = 2'd3
    } state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    vih_q, vil_q;
    logic [WIDTH-1:0]    stop_q, step_q, gap_q;
    logic [SETTLE_W-1:0] settle_q, cnt_q;
    logic                req_q, busy_q, done_q;

    logic [WIDTH:0]      sum_d;
    logic                last_d;
    logic [WIDTH-1:0]    vil_start_d, vil_step_d;

    // a - b clamped at zero; a carries one extra bit so the next-point sum fits
    function automatic logic [WIDTH-1:0] sat0(input logic [WIDTH:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] diff;
        diff = a - {1'b0, b};
        if (a >= {1'b0, b}) return diff[WIDTH-1:0];
        else                return '0;
    endfunction

    assign sum_d       = {1'b0, vih_q} + {1'b0, step_q};
    assign last_d      = (step_q == '0) || (sum_d > {1'b0, stop_q});
    assign vil_start_d = sat0({1'b0, bus.vih_start}, bus.gap);
    assign vil_step_d  = sat0(sum_d, gap_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            vih_q    <= '0;
            vil_q    <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            gap_q    <= '0;
            settle_q <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && bus.abort) begin
                // abort outranks both the capture handshake and the step decision
                state_q <= IDLE;
                req_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            stop_q   <= bus.vih_stop;
                            step_q   <= bus.step;
                            gap_q    <= bus.gap;
                            settle_q <= bus.settle;
                            vih_q    <= bus.vih_start;
                            vil_q    <= vil_start_d;
                            cnt_q    <= bus.settle;
                            busy_q   <= 1'b1;
                            state_q  <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        if (bus.sample_ack) begin
                            req_q   <= 1'b0;
                            state_q <= STEP;
                        end
                    end
                    STEP: begin
                        if (last_d) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            vih_q   <= sum_d[WIDTH-1:0];
                            vil_q   <= vil_step_d;
                            cnt_q   <= settle_q;
                            state_q <= SETTLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.VIH        = vih_q;
    assign bus.VIL        = vil_q;
    assign bus.sample_req = req_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_vth_sweep_ctrl.sv
// Directed bench for vth_sweep_ctrl: expected sweep points go into a queue,
// a monitor pops and checks them as sample_req rises.
`timescale 1ns/1ps
module tb_vth_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] state_o;

  vth_sweep_ctrl_if #(.WIDTH(8), .SETTLE_W(16)) bus ();

  vth_sweep_ctrl #(.WIDTH(8), .SETTLE_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // entry = {VIH, VIL, cycles from VIH update to sample_req rise, sample_req high cycles}
  logic [31:0] exp_q[$];
  int          exp_done = 0;

  int ack_tied  = 1;
  int ack_delay = 7;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // ---------------- ack driver ----------------
  initial begin
    bus.sample_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_tied != 0) begin
        bus.sample_ack = 1'b1;
      end else begin
        bus.sample_ack = 1'b0;
        if (bus.sample_req) begin
          repeat (ack_delay - 1) @(negedge clk);
          bus.sample_ack = 1'b1;
          @(negedge clk);
          bus.sample_ack = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [7:0] prev_vih  = '0;
  logic       prev_busy = 1'b0;
  logic       prev_req  = 1'b0;
  int         since_upd = 0;
  int         hold_cnt  = 0;
  int         hold_exp  = 0;

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_vih  = '0;
        prev_busy = 1'b0;
        prev_req  = 1'b0;
        since_upd = 0;
        hold_cnt  = 0;
      end else begin
        if ((bus.VIH != prev_vih) || (bus.busy && !prev_busy)) since_upd = 0;
        else since_upd++;
        if (bus.sample_req && !prev_req) begin
          if (exp_q.size() == 0) begin
            check("unexpected_sample_req", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("point_vih", int'(bus.VIH), int'(e[31:24]));
            check("point_vil", int'(bus.VIL), int'(e[23:16]));
            check("req_latency", since_upd, int'(e[15:8]));
            hold_exp = int'(e[7:0]);
          end
          hold_cnt = 1;
        end else if (bus.sample_req) begin
          hold_cnt++;
        end
        if (!bus.sample_req && prev_req) check("req_hold_cycles", hold_cnt, hold_exp);
        if (bus.done) begin
          check("done_expected", int'(exp_done > 0), 1);
          check("done_busy_low", int'(bus.busy), 0);
          if (exp_done > 0) exp_done--;
        end
        prev_vih  = bus.VIH;
        prev_busy = bus.busy;
        prev_req  = bus.sample_req;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic void push_pt(input int vih, input int vil, input int lat, input int hold);
    exp_q.push_back({vih[7:0], vil[7:0], lat[7:0], hold[7:0]});
  endfunction

  task automatic start_sweep(input logic [7:0] vs, input logic [7:0] stop,
                             input logic [7:0] stp, input logic [7:0] gp,
                             input logic [15:0] st);
    @(negedge clk);
    bus.vih_start = vs;
    bus.vih_stop  = stop;
    bus.step      = stp;
    bus.gap       = gp;
    bus.settle    = st;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 1000; i++) begin
      if (!bus.busy) break;
      @(negedge clk);
    end
    check(name, int'(bus.busy), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_vih"},   int'(bus.VIH), 0);
    check({tag, "_vil"},   int'(bus.VIL), 0);
    check({tag, "_busy"},  int'(bus.busy), 0);
    check({tag, "_req"},   int'(bus.sample_req), 0);
    check({tag, "_done"},  int'(bus.done), 0);
    check({tag, "_state"}, int'(state_o), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.vih_start = '0; bus.vih_stop = '0; bus.step = '0; bus.gap = '0; bus.settle = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_clear("reset");
    rst = 1'b0;

    // basic sweep 10..30 step 10, gap 3, settle 4
    push_pt(10, 7, 5, 1); push_pt(20, 17, 5, 1); push_pt(30, 27, 5, 1);
    exp_done++;
    start_sweep(8'd10, 8'd30, 8'd10, 8'd3, 16'd4);
    wait_idle("basic_idle");
    check("basic_vih_hold", int'(bus.VIH), 30);
    check("basic_vil_hold", int'(bus.VIL), 27);

    // VIL saturates at zero, single point
    push_pt(2, 0, 1, 1); exp_done++;
    start_sweep(8'd2, 8'd2, 8'd1, 8'd5, 16'd0);
    wait_idle("sat_idle");

    // 250 + 10 would exceed 255: one point, no wrap
    push_pt(250, 250, 2, 1); exp_done++;
    start_sweep(8'd250, 8'd255, 8'd10, 8'd0, 16'd1);
    wait_idle("nowrap_idle");
    check("nowrap_vih", int'(bus.VIH), 250);

    // start above stop still gives one point
    push_pt(100, 80, 4, 1); exp_done++;
    start_sweep(8'd100, 8'd50, 8'd5, 8'd20, 16'd3);
    wait_idle("rev_idle");

    // step of zero ends after the first point
    push_pt(5, 4, 1, 1); exp_done++;
    start_sweep(8'd5, 8'd200, 8'd0, 8'd1, 16'd0);
    wait_idle("step0_idle");

    // abort while settling the second point
    push_pt(10, 7, 5, 1);
    start_sweep(8'd10, 8'd30, 8'd10, 8'd3, 16'd4);
    for (int i = 0; i < 200; i++) begin
      if (bus.VIH == 8'd20) break;
      @(negedge clk);
    end
    check("abort_reach_pt2", int'(bus.VIH), 20);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_req", int'(bus.sample_req), 0);
    check("abort_vih", int'(bus.VIH), 20);
    check("abort_vil", int'(bus.VIL), 17);
    check("abort_state", int'(state_o), 0);
    repeat (10) @(negedge clk);

    // slow ack; start pulse and config changes mid-sweep must be ignored
    ack_tied = 0;
    push_pt(40, 30, 3, 7); push_pt(60, 50, 3, 7); exp_done++;
    start_sweep(8'd40, 8'd60, 8'd20, 8'd10, 16'd2);
    repeat (3) @(negedge clk);
    bus.vih_start = 8'd1; bus.vih_stop = 8'd255; bus.step = 8'd1; bus.gap = 8'd0; bus.settle = 16'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("slow_idle");
    check("slow_vih_hold", int'(bus.VIH), 60);
    ack_tied = 1;

    // asynchronous reset in the middle of SETTLE
    start_sweep(8'd10, 8'd30, 8'd10, 8'd3, 16'd4);
    check("pre_reset_busy", int'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    check_outputs_clear("async_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    check("leftover_points", exp_q.size(), 0);
    check("leftover_done", exp_done, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
